// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: REQ/WAIT/VALID handshake toward imem and decoder.
// Optional performance counters are enabled by defining IFU_PERF_COUNTERS_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    input  logic [DATA_WIDTH-1:0] dnpc,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
);

    localparam logic [DATA_WIDTH-1:0] NopInst = 32'h0000_0013;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StValid,
        StFault
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [1:0]            cause_q, cause_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            inst_q  <= NopInst;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cause_d = cause_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_req_ready) state_d = StWait;
            end
            StWait: begin
                // Responses are only meaningful here; other states drop them.
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = StFault;
                        cause_d = 2'b01;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = StValid;
                    end
                end
            end
            StValid: begin
                if (inst_ready) begin
                    if (dnpc[1:0] == 2'b00) begin
                        pc_d    = dnpc;
                        state_d = StReq;
                    end else begin
                        state_d = StFault;
                        cause_d = 2'b10;
                    end
                end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    assign imem_req_valid = (state_q == StReq);
    assign imem_addr      = pc_q;
    assign inst_valid     = (state_q == StValid);
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign fault          = (state_q == StFault);
    assign fault_cause    = cause_q;

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // A fetch is incomplete from the first REQ cycle until its response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == StValid && inst_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (state_q == StReq || (state_q == StWait && !imem_rsp_valid)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized memory/decoder
// run checked against a transaction-level model of the expected pc/instruction stream.
module tb_ifu_fetch;

    localparam logic [31:0] RstPc = 32'h8000_0000;
    localparam logic [31:0] Nop   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] pc, inst, dnpc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic        pending;
    logic [31:0] pend_addr;
    int          lat;
    int          cyc, last_hs, n_hs;
    logic [31:0] m_fetch, m_stall;

    ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .pc            (pc),
        .inst          (inst),
        .dnpc          (dnpc),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        dnpc           = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst       = 1'b0;
        exp_pc    = RstPc;
        pending   = 1'b0;
        pend_addr = 32'h0;
        lat       = 0;
        cyc       = 0;
        last_hs   = 0;
        n_hs      = 0;
        m_fetch   = 32'h0;
        m_stall   = 32'h0;
    endtask

    // Reach VALID from the IDLE cycle following do_reset, delivering word d.
    task automatic goto_valid(input logic [31:0] d);
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    // One cycle of the memory/decoder environment with model checks.
    // mode 0: dnpc = pc+4; mode 1: random mix of sequential, self-loop and aligned jumps.
    task automatic run_cycle(input int ready_pct, input int lat_max, input int iready_pct,
                             input bit spurious, input int mode, input bit gap_chk);
        logic        was_pending;
        logic [31:0] nxt;
        if (imem_req_valid) begin
            n_tests++;
            if (imem_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL req_addr: got %h expected %h (cyc %0d)", imem_addr, exp_pc, cyc);
            end
        end
        if (inst_valid) begin
            n_tests++;
            if (pc !== exp_pc || inst !== inst_of(exp_pc) || imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_out: pc %h inst %h req %b expected pc %h inst %h req 0",
                         pc, inst, imem_req_valid, exp_pc, inst_of(exp_pc));
            end
        end
        if (fault !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL no_fault: got fault %b cause %b expected 0", fault, fault_cause);
        end
`ifdef IFU_PERF_COUNTERS_EN
        n_tests++;
        if (perf_fetch_cnt !== m_fetch || perf_stall_cnt !== m_stall) begin
            n_fail++;
            $display("FAIL perf: got %0d/%0d expected %0d/%0d",
                     perf_fetch_cnt, perf_stall_cnt, m_fetch, m_stall);
        end
`else
        n_tests++;
        if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL perf_tied: got %h/%h expected 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        // Drive
        was_pending    = pending;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        imem_rsp_err   = 1'b0;
        if (pending) begin
            if (lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(pend_addr);
                pending        = 1'b0;
            end else begin
                lat--;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end else begin
            // No fetch outstanding: any response here must be ignored.
            imem_rsp_valid = spurious && ($urandom_range(3) == 0);
            imem_rsp_err   = $urandom_range(1) == 1;
            imem_rsp_data  = $urandom;
        end
        if (imem_req_valid && imem_req_ready) begin
            pending   = 1'b1;
            pend_addr = imem_addr;
            lat       = $urandom_range(lat_max);
        end
        inst_ready = ($urandom_range(99) < iready_pct);
        dnpc       = $urandom;
        if (inst_valid && inst_ready) begin
            if (mode == 0) begin
                nxt = exp_pc + 32'd4;
            end else begin
                case ($urandom_range(3))
                    0:       nxt = exp_pc;
                    1:       nxt = {$urandom, 2'b00} >> 2 << 2;
                    default: nxt = exp_pc + 32'd4;
                endcase
                nxt[1:0] = 2'b00;
            end
            dnpc = nxt;
            if (gap_chk) begin
                n_tests++;
                if (cyc - last_hs != 3) begin
                    n_fail++;
                    $display("FAIL hs_gap: got %0d cycles expected 3 (pc %h)", cyc - last_hs,
                             exp_pc);
                end
            end
            last_hs = cyc;
            n_hs++;
            exp_pc = nxt;
            m_fetch++;
        end
        if (imem_req_valid || (was_pending && !imem_rsp_valid)) m_stall++;
        tick();
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        tick();
        n_tests++;
        if (pc !== RstPc || inst !== Nop || inst_valid !== 1'b0 || imem_req_valid !== 1'b0 ||
            fault !== 1'b0 || fault_cause !== 2'b00 || perf_fetch_cnt !== 32'h0 ||
            perf_stall_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vals: pc %h inst %h iv %b rv %b f %b c %b cnt %h/%h", pc, inst,
                     inst_valid, imem_req_valid, fault, fault_cause, perf_fetch_cnt,
                     perf_stall_cnt);
        end
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        tick();
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RstPc || inst !== Nop) begin
            n_fail++;
            $display("FAIL first_req: rv %b addr %h inst %h expected 1 %h %h", imem_req_valid,
                     imem_addr, inst, RstPc, Nop);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 60 && n_hs < 4; i++) run_cycle(100, 0, 100, 1'b0, 0, 1'b1);
        n_tests++;
        if (n_hs != 4 || exp_pc !== RstPc + 32'd16) begin
            n_fail++;
            $display("FAIL zero_wait: got %0d handshakes next pc %h expected 4 %h", n_hs, exp_pc,
                     RstPc + 32'd16);
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_addr !== RstPc) begin
                n_fail++;
                $display("FAIL req_hold: rv %b addr %h expected 1 %h", imem_req_valid, imem_addr,
                         RstPc);
            end
            imem_req_ready = (i == 4);
            tick();
        end
        imem_req_ready = 1'b0;
        n_tests++;
`ifdef IFU_PERF_COUNTERS_EN
        if (imem_req_valid !== 1'b0 || perf_stall_cnt !== 32'd5) begin
`else
        if (imem_req_valid !== 1'b0 || perf_stall_cnt !== 32'd0) begin
`endif
            n_fail++;
            $display("FAIL req_accept: rv %b stall %0d", imem_req_valid, perf_stall_cnt);
        end
    endtask

    task automatic test_valid_stall();
        do_reset();
        goto_valid(32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (inst_valid !== 1'b1 || pc !== RstPc || inst !== 32'h1234_5678 ||
                imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_hold: iv %b pc %h inst %h rv %b", inst_valid, pc, inst,
                         imem_req_valid);
            end
            inst_ready = 1'b0;
            dnpc       = 32'hFFFF_FFF3;
            tick();
        end
        inst_ready = 1'b1;
        dnpc       = RstPc + 32'd8;
        tick();
        inst_ready = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RstPc + 32'd8 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_release: rv %b addr %h iv %b expected 1 %h 0", imem_req_valid,
                     imem_addr, inst_valid, RstPc + 32'd8);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        goto_valid(32'hCAFE_0001);
        inst_ready = 1'b1;
        dnpc       = 32'h8000_0102;
        tick();
        n_tests++;
        if (fault !== 1'b1 || fault_cause !== 2'b10 || pc !== RstPc || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign: f %b cause %b pc %h iv %b expected 1 10 %h 0", fault,
                     fault_cause, pc, inst_valid, RstPc);
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imem_rsp_valid = $urandom_range(1) == 1;
            dnpc           = RstPc;
            tick();
            n_tests++;
            if (imem_req_valid !== 1'b0 || fault !== 1'b1 || inst_valid !== 1'b0 ||
                fault_cause !== 2'b10) begin
                n_fail++;
                $display("FAIL fault_sticky: rv %b f %b iv %b cause %b", imem_req_valid, fault,
                         inst_valid, fault_cause);
            end
        end
        clear_inputs();
    endtask

    task automatic test_rsp_err();
        do_reset();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        tick();
        n_tests++;
        if (imem_req_valid !== 1'b1 || fault !== 1'b0 || fault_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL rsp_in_req: rv %b f %b cause %b expected 1 0 00", imem_req_valid,
                     fault, fault_cause);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        clear_inputs();
        n_tests++;
        if (fault !== 1'b1 || fault_cause !== 2'b01 || inst_valid !== 1'b0 || inst !== Nop) begin
            n_fail++;
            $display("FAIL access_err: f %b cause %b iv %b inst %h expected 1 01 0 %h", fault,
                     fault_cause, inst_valid, inst, Nop);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst            = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_F00D;
        tick();
        rst = 1'b0;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RstPc || inst !== Nop ||
            inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_rsp: rv %b addr %h inst %h iv %b", imem_req_valid, imem_addr,
                     inst, inst_valid);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        n_tests++;
        if (inst !== Nop || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_wait: inst %h rv %b iv %b expected %h 0 0", inst,
                     imem_req_valid, inst_valid, Nop);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_1111;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_1111 || pc !== RstPc) begin
            n_fail++;
            $display("FAIL restart_fetch: iv %b inst %h pc %h", inst_valid, inst, pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000 && n_hs < 150; i++) run_cycle(60, 3, 60, 1'b1, 1, 1'b0);
        n_tests++;
        if (n_hs < 150) begin
            n_fail++;
            $display("FAIL random_timeout: got %0d handshakes expected 150", n_hs);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_req_stall();
        test_valid_stall();
        test_misaligned();
        test_rsp_err();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
